// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and configuration checks for the sequence detector
package seq_det_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Entry n is the active-high a..g pattern for hex digit n, bit 0 = segment a.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic bit len_w_ok(input int max_len, input int len_w);
        return (max_len >= 2) && (max_len <= 16) && ((1 << len_w) > max_len);
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// rtl/hex_to_7seg.sv - combinational 4-bit to active-high seven-segment decoder
module hex_to_7seg
    import seq_det_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG_TABLE[i_nibble];

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - programmable serial pattern detector with saturating match count
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                   MAX_LEN     = 8,
    parameter int                   LEN_W       = 4,
    parameter int                   CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]   DEFAULT_PAT = MAX_LEN'(8'b0000_0100),
    parameter int                   DEFAULT_LEN = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               bit_in,
    input  logic               bit_valid,
    input  logic               pat_load,
    input  logic [MAX_LEN-1:0] pat_data,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap_en,
    input  logic               clr_count,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic [7:0]         seg
);

    if (!len_w_ok(MAX_LEN, LEN_W)) begin : g_bad_len_cfg
        $error("seq_detector_param: MAX_LEN must be 2..16 and 2**LEN_W > MAX_LEN");
    end
    if (CNT_W < 4) begin : g_bad_cnt_cfg
        $error("seq_detector_param: CNT_W must be at least 4 to drive the display");
    end

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_match;
    logic [CNT_W-1:0]   r_count;

    logic [MAX_LEN-1:0] w_hist_next;
    logic [LEN_W-1:0]   w_fill_next;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_len_clamped;
    logic               w_hit;
    logic               w_accept;
    logic [6:0]         w_seg7;

    assign w_hist_next = {r_hist[MAX_LEN-2:0], bit_in};
    assign w_fill_next = (r_fill == MAX_LEN_L) ? r_fill : r_fill + 1'b1;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    // Compare against the state the accepted bit would produce, so the pulse lands on that same edge.
    assign w_hit = (w_fill_next >= r_len) && (((w_hist_next ^ r_pat) & w_mask) == '0);

    always_comb begin
        w_len_clamped = pat_len;
        if (pat_len == '0) begin
            w_len_clamped = LEN_W'(1);
        end else if (pat_len > MAX_LEN_L) begin
            w_len_clamped = MAX_LEN_L;
        end
    end

    assign w_accept = ena && !pat_load && bit_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_pat   <= DEFAULT_PAT;
            r_len   <= LEN_W'(DEFAULT_LEN);
            r_match <= 1'b0;
        end else if (!ena) begin
            r_match <= 1'b0;
        end else if (pat_load) begin
            r_pat   <= pat_data;
            r_len   <= w_len_clamped;
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else if (bit_valid) begin
            r_hist  <= w_hist_next;
            r_fill  <= (w_hit && !overlap_en) ? '0 : w_fill_next;
            r_match <= w_hit;
        end else begin
            r_match <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (ena) begin
            if (clr_count) begin
                r_count <= '0;
            end else if (w_accept && w_hit && (r_count != CNT_MAX)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    hex_to_7seg u_hex_to_7seg (
        .i_nibble (r_count[3:0]),
        .o_seg    (w_seg7)
    );

    assign seg[SEG_G:SEG_A] = w_seg7;
    assign seg[SEG_DP]      = r_match;
    assign match            = r_match;
    assign match_count      = r_count;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed self-checking bench for seq_detector_param
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               ena;
    logic               bit_in;
    logic               bit_valid;
    logic               pat_load;
    logic [MAX_LEN-1:0] pat_data;
    logic [LEN_W-1:0]   pat_len;
    logic               overlap_en;
    logic               clr_count;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic [7:0]         seg;

    int checks   = 0;
    int failures = 0;

    seq_detector_param #(
        .MAX_LEN     (MAX_LEN),
        .LEN_W       (LEN_W),
        .CNT_W       (CNT_W),
        .DEFAULT_PAT (8'b0000_0100),
        .DEFAULT_LEN (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .pat_load    (pat_load),
        .pat_data    (pat_data),
        .pat_len     (pat_len),
        .overlap_en  (overlap_en),
        .clr_count   (clr_count),
        .match       (match),
        .match_count (match_count),
        .seg         (seg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input logic [MAX_LEN-1:0] d, input logic [LEN_W-1:0] l);
        pat_data = d;
        pat_len  = l;
        pat_load = 1'b1;
        tick();
        pat_load = 1'b0;
    endtask

    task automatic clear_count();
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; bit_in = 1'b0; bit_valid = 1'b0;
        pat_load = 1'b0; pat_data = '0; pat_len = '0; overlap_en = 1'b1; clr_count = 1'b0;
        idle(2);
        check("rst_match", match, 0);
        check("rst_count", match_count, 0);
        check("rst_seg", seg, 8'h3F);
        rst_n = 1'b1;
        idle(1);

        // default pattern 100, length 3
        send_bit(1); check("def_b1", match, 0);
        send_bit(0); check("def_b2", match, 0);
        send_bit(0); check("def_b3", match, 1);
        check("def_count", match_count, 1);
        check("def_seg_dp", seg, 8'h86);
        idle(1);
        check("def_idle_seg", seg, 8'h06);
        check("def_idle_match", match, 0);

        // overlapping 1010
        overlap_en = 1'b1;
        load(8'b1010, 4'd4);
        clear_count();
        send_bit(1); send_bit(0); send_bit(1);
        check("ov_b3", match, 0);
        send_bit(0); check("ov_b4", match, 1);
        send_bit(1); check("ov_b5", match, 0);
        send_bit(0); check("ov_b6", match, 1);
        check("ov_count", match_count, 2);

        // non-overlapping 1010
        overlap_en = 1'b0;
        load(8'b1010, 4'd4);
        clear_count();
        send_bit(1); send_bit(0); send_bit(1);
        send_bit(0); check("nov_b4", match, 1);
        send_bit(1); check("nov_b5", match, 0);
        send_bit(0); check("nov_b6", match, 0);
        check("nov_count", match_count, 1);
        overlap_en = 1'b1;

        // length 0 clamps to 1
        load(8'b1, 4'd0);
        send_bit(0); check("len0_b1", match, 0);
        send_bit(1); check("len0_b2", match, 1);

        // length 15 clamps to 8
        load(8'b1100_1010, 4'd15);
        send_bit(1); send_bit(1); send_bit(0); send_bit(0);
        send_bit(1); send_bit(0); send_bit(1);
        check("len15_b7", match, 0);
        send_bit(0); check("len15_b8", match, 1);

        // bit_valid on the load edge is discarded
        pat_data = 8'b100; pat_len = 4'd3; pat_load = 1'b1;
        bit_in = 1'b1; bit_valid = 1'b1;
        tick();
        pat_load = 1'b0; bit_valid = 1'b0;
        check("prio_load_match", match, 0);
        send_bit(0); send_bit(0);
        check("prio_no_match", match, 0);
        send_bit(1); send_bit(0); send_bit(0);
        check("prio_fresh_match", match, 1);

        // gaps and ena=0 between pattern bits
        clear_count();
        send_bit(1);
        idle(2);
        ena = 1'b0; bit_in = 1'b0; bit_valid = 1'b1;
        idle(2);
        bit_valid = 1'b0; ena = 1'b1;
        check("gap_ena_count", match_count, 0);
        send_bit(0); check("gap_b2", match, 0);
        idle(1);
        send_bit(0); check("gap_b3", match, 1);
        check("gap_count", match_count, 1);
        ena = 1'b0;
        tick();
        check("ena_low_match", match, 0);
        check("ena_low_count", match_count, 1);
        ena = 1'b1;

        // saturation with CNT_W=4, one-bit pattern
        load(8'b1, 4'd1);
        clear_count();
        for (int i = 0; i < 15; i++) send_bit(1);
        check("sat_15", match_count, 15);
        send_bit(1); send_bit(1);
        check("sat_17", match_count, 15);
        check("sat_seg", seg, 8'hF1);
        bit_in = 1'b1; bit_valid = 1'b1; clr_count = 1'b1;
        tick();
        bit_valid = 1'b0; clr_count = 1'b0;
        check("clr_wins_count", match_count, 0);
        check("clr_wins_match", match, 1);
        check("clr_wins_seg", seg, 8'hBF);

        // async reset mid-pattern restores defaults
        load(8'b100, 4'd3);
        send_bit(1); send_bit(0); send_bit(0);
        check("pre_rst_count", match_count, 1);
        send_bit(1); send_bit(0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", match_count, 0);
        check("async_rst_seg", seg, 8'h3F);
        tick();
        rst_n = 1'b1;
        send_bit(0); check("post_rst_no_match", match, 0);
        load(8'b1, 4'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        send_bit(1); send_bit(0);
        check("def_pat_b2", match, 0);
        send_bit(0); check("def_pat_restored", match, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial sequence detector with a runtime-programmable pattern and length, selectable overlapping/non-overlapping detection, and a saturating match counter. The low nibble of the counter drives an active-high seven-segment display in hex; the decimal point flags the match pulse. It replaces the fixed 3-state detector in the Tiny Tapeout wrapper and is driven from ui_in/uio_in by the top level.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
LEN_W, 4, width of the pattern-length field; must satisfy 2**LEN_W > MAX_LEN
CNT_W, 8, match counter width
DEFAULT_PAT, 8'b0000_0100, pattern loaded at reset (LSB-aligned)
DEFAULT_LEN, 3, pattern length loaded at reset

Ports:
clk  in  1  system clock
rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
ena  in  1  block enable; when low, all state holds
bit_in  in  1  serial data bit
bit_valid  in  1  bit_in is sampled on a clock edge where bit_valid=1
pat_load  in  1  capture pat_data/pat_len this cycle
pat_data  in  MAX_LEN  new pattern, LSB-aligned; bit 0 = last bit received
pat_len  in  LEN_W  new pattern length
overlap_en  in  1  1 = overlapping detection, 0 = non-overlapping
clr_count  in  1  synchronous clear of match_count
match  out  1  one-cycle pulse, registered
match_count  out  CNT_W  saturating count of matches
seg  out  8  seg[0]=a .. seg[6]=g, seg[7]=dp; active high

Behaviour:
- Async reset: hist=0, fill=0, pattern=DEFAULT_PAT, length=DEFAULT_LEN, match=0, match_count=0, seg=hex "0" (8'h3F).
- ena=0: no register updates except match, which is forced to 0. All inputs are ignored.
- Length clamp at load: pat_len=0 is stored as 1; pat_len>MAX_LEN is stored as MAX_LEN.
- Priority per enabled edge: pat_load > bit_valid.
  - pat_load: stores the pattern and the clamped length, clears hist and fill, sets match=0. A bit_valid on the same edge is discarded.
- Accepted bit: hist <= {hist[MAX_LEN-2:0], bit_in}; fill increments and saturates at MAX_LEN.
- Match condition, evaluated on the next state:
  - fill_next >= len, and
  - hist_next[len-1:0] == pattern[len-1:0]. Bits above len are masked.
- Latency: match goes high on the same edge that accepts the final pattern bit, so it is visible one cycle after that bit is presented. It lasts exactly one cycle unless the next bit also completes a match.
- After a match:
  - overlap_en=1: hist and fill are retained.
  - overlap_en=0: fill <= 0 on the matching edge, so the next match needs len fresh bits.
- overlap_en is sampled on the matching edge. Changing it mid-stream is legal.
- No bit_valid: hist, fill and match do not change (match <= 0).
- match_count increments on the edge that sets match, and saturates at 2**CNT_W-1.
  - clr_count on the same edge as a match: clear wins, count = 0.
- seg is combinational from registered state:
  - seg[6:0] = hex7seg(match_count[3:0]); digits 0-F, standard a-g.
  - seg[7] = match.
- Reset asserted mid-stream: everything returns to reset values immediately, and any partial match is lost.

Decomposition:
- Package seq_det_pkg: the MAX_LEN/LEN_W relation check, the SEG_* bit-index constants, and the 16-entry hex segment constant table.
- One sub-module, hex_to_7seg: 4-bit in, 7-bit active-high segments out, purely combinational. It is reused by later display blocks.
- FSM-free datapath: history shifter, fill counter, masked comparator, counter.

Test Plan:
- Reset defaults (pattern 100, len 3): stream 1,0,0 with bit_valid=1 -> match=1 exactly one cycle after the third bit; match_count=1; seg=8'h86 (hex 1 plus dp). Next idle cycle -> seg=8'h06.
- Overlap: load pat 1010, len 4, overlap_en=1; stream 1,0,1,0,1,0 -> match after bits 4 and 6, count=2. Same stream with overlap_en=0 -> one match after bit 4, count=1.
- Load, clamp and priority:
  - pat_len=0 with pat_data=1, then stream 0,1 -> match after the second bit only.
  - pat_len=15 (MAX_LEN=8) -> length is 8; stream 8 bits equal to pat_data -> match on bit 8.
  - pat_load with bit_valid on the same edge -> that bit is discarded and fill=0.
- Gaps and enable: insert bit_valid=0 cycles and ena=0 cycles between pattern bits -> the match still fires on the final valid bit. A match completed just before ena drops -> match=0 while ena=0.
- Counter: CNT_W=4; force 17 matches -> count saturates at 15 (seg shows F). clr_count on the same edge as a match -> count=0. Async reset mid-pattern (after 1,0) then 0 -> no match.
